// File: rtl/fcvt_arbiter.sv
// fcvt_arbiter: shares one fixed-latency ftoi unit between two requesters using
// credit-based issue and per-requester response FIFOs. Define FCVT_ARB_RR_EN for round-robin.

module fcvt_rsp_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 36
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop,
  output logic                   valid,
  output logic [W-1:0]           head,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; a full-FIFO push overwrites the head slot only after it is read.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  assign valid = (count != '0);
  assign head  = mem[rptr];
endmodule

module fcvt_arbiter #(
  parameter int NSTAGE     = 2,
  parameter int TAGW       = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic            req1_valid,
  output logic            req0_ready,
  output logic            req1_ready,
  input  logic [31:0]     req0_x,
  input  logic [31:0]     req1_x,
  input  logic [TAGW-1:0] req0_tag,
  input  logic [TAGW-1:0] req1_tag,
  output logic [31:0]     cvt_x,
  input  logic [31:0]     cvt_y,
  output logic            rsp0_valid,
  output logic            rsp1_valid,
  input  logic            rsp0_ready,
  input  logic            rsp1_ready,
  output logic [31:0]     rsp0_y,
  output logic [31:0]     rsp1_y,
  output logic [TAGW-1:0] rsp0_tag,
  output logic [TAGW-1:0] rsp1_tag,
  output logic            busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int UW = $clog2(FIFO_DEPTH + NSTAGE + 1) + 1;
  localparam int RW = 32 + TAGW;

  typedef struct packed {
    logic            owner;
    logic [TAGW-1:0] tag;
  } meta_t;

  logic [1:0]            req_valid, rsp_ready, elig, gnt, push, pop, rvld;
  logic [1:0][31:0]      req_x;
  logic [1:0][TAGW-1:0]  req_tag;
  logic [1:0][CW-1:0]    cnt;
  logic [1:0][UW-1:0]    used;
  logic [1:0][RW-1:0]    rsp_head;
  logic [NSTAGE-1:0]     vld_pipe;
  meta_t                 meta_pipe [NSTAGE];
  logic                  iss_vld;
  meta_t                 iss_meta;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign req_x     = {req1_x, req0_x};
  assign req_tag   = {req1_tag, req0_tag};

  // Occupancy = FIFO entries + in-flight ops owned by the port, from registered state only.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      used[i] = UW'(cnt[i]);
      for (int s = 0; s < NSTAGE; s++)
        used[i] = used[i] + UW'(vld_pipe[s] && meta_pipe[s].owner == 1'(i));
      elig[i] = req_valid[i] && (used[i] < UW'(FIFO_DEPTH)) && !rst;
    end
  end

`ifdef FCVT_ARB_RR_EN
  logic rr_ptr;  // 1: port 1 wins the next contention

  always_comb begin
    gnt = 2'b00;
    if (elig[0] && (!elig[1] || !rr_ptr)) gnt[0] = 1'b1;
    else if (elig[1])                     gnt[1] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rr_ptr <= 1'b0;
    else if (|gnt) rr_ptr <= gnt[0];
  end
`else
  always_comb begin
    gnt[0] = elig[0];
    gnt[1] = elig[1] && !elig[0];
  end
`endif

  assign req0_ready     = gnt[0];
  assign req1_ready     = gnt[1];
  assign cvt_x          = gnt[1] ? req_x[1] : (gnt[0] ? req_x[0] : 32'h0);
  assign iss_vld        = |gnt;
  assign iss_meta.owner = gnt[1];
  assign iss_meta.tag   = gnt[1] ? req_tag[1] : req_tag[0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int s = 0; s < NSTAGE; s++) meta_pipe[s] <= '0;
    end else begin
      vld_pipe[0]  <= iss_vld;
      meta_pipe[0] <= iss_meta;
      for (int s = 1; s < NSTAGE; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        meta_pipe[s] <= meta_pipe[s-1];
      end
    end
  end

  for (genvar i = 0; i < 2; i++) begin : g_port
    assign push[i] = vld_pipe[NSTAGE-1] && (meta_pipe[NSTAGE-1].owner == 1'(i));
    assign pop[i]  = rvld[i] && rsp_ready[i];

    fcvt_rsp_fifo #(.DEPTH(FIFO_DEPTH), .W(RW)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push[i]),
      .push_data ({cvt_y, meta_pipe[NSTAGE-1].tag}),
      .pop       (pop[i]),
      .valid     (rvld[i]),
      .head      (rsp_head[i]),
      .count     (cnt[i])
    );
  end

  assign rsp0_valid = rvld[0];
  assign rsp1_valid = rvld[1];
  assign rsp0_y     = rsp_head[0][RW-1:TAGW];
  assign rsp1_y     = rsp_head[1][RW-1:TAGW];
  assign rsp0_tag   = rsp_head[0][TAGW-1:0];
  assign rsp1_tag   = rsp_head[1][TAGW-1:0];
  assign busy       = (|vld_pipe) || (|rvld);
endmodule

// File: tb/tb_fcvt_arbiter.sv
// Bench for fcvt_arbiter: models the ftoi unit, runs a directed vector table and
// multi-cycle sequences (contention, backpressure, full-FIFO push/pop, mid-flight reset).

module tb_fcvt_arbiter;
  localparam int NSTAGE = 2, TAGW = 4, FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req1_valid, req0_ready, req1_ready;
  logic [31:0] req0_x, req1_x, cvt_x, cvt_y, rsp0_y, rsp1_y;
  logic [TAGW-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready, busy;

  always #5 clk = ~clk;

  fcvt_arbiter #(.NSTAGE(NSTAGE), .TAGW(TAGW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_x(req0_x), .req1_x(req1_x), .req0_tag(req0_tag), .req1_tag(req1_tag),
    .cvt_x(cvt_x), .cvt_y(cvt_y),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_y(rsp0_y), .rsp1_y(rsp1_y), .rsp0_tag(rsp0_tag), .rsp1_tag(rsp1_tag),
    .busy(busy)
  );

  // float -> int, round half away from zero (enough range for the operands used here)
  function automatic logic [31:0] f2i(input logic [31:0] x);
    int e;
    longint m, r;
    e = int'(x[30:23]) - 127;
    if (e < -1) return 32'h0;
    m = longint'({1'b1, x[22:0]});
    if (e >= 23) r = m <<< (e - 23);
    else         r = (m + (64'sd1 <<< (22 - e))) >>> (23 - e);
    return x[31] ? 32'(-r) : 32'(r);
  endfunction

  function automatic logic [31:0] i2f(input int n);
    int e;
    logic [31:0] m;
    if (n == 0) return 32'h0;
    e = 0;
    for (int b = 0; b < 31; b++) if (n[b]) e = b;
    m = 32'(n) << (23 - e);
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  // ftoi stand-in: unreset, unstalled, fixed NSTAGE latency
  logic [31:0] fpipe [NSTAGE];
  always @(posedge clk) begin
    fpipe[0] <= f2i(cvt_x);
    for (int s = 1; s < NSTAGE; s++) fpipe[s] <= fpipe[s-1];
  end
  assign cvt_y = fpipe[NSTAGE-1];

  int n_run = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: op n on a port carries x=float(n), tag=n, so the result must be n
  typedef struct { int y; logic [TAGW-1:0] tag; } exp_t;
  exp_t q0[$], q1[$];
  int   seq0, seq1, pops0, pops1;
  bit   mon_en = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      q0.delete(); q1.delete();
      seq0 = 0; seq1 = 0; pops0 = 0; pops1 = 0;
    end else if (mon_en) begin
      if (req0_valid && req0_ready) begin q0.push_back('{seq0, TAGW'(seq0)}); seq0++; end
      if (req1_valid && req1_ready) begin q1.push_back('{seq1, TAGW'(seq1)}); seq1++; end
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) check("rsp0_unexpected", 32'(q0.size()), 32'd1);
        else begin
          e = q0.pop_front(); pops0++;
          check("rsp0_y", rsp0_y, 32'(e.y));
          check("rsp0_tag", 32'(rsp0_tag), 32'(e.tag));
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) check("rsp1_unexpected", 32'(q1.size()), 32'd1);
        else begin
          e = q1.pop_front(); pops1++;
          check("rsp1_y", rsp1_y, 32'(e.y));
          check("rsp1_tag", 32'(rsp1_tag), 32'(e.tag));
        end
      end
    end
  end

  // Inputs only change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk); #1;
    if (mon_en) begin
      req0_x = i2f(seq0); req0_tag = TAGW'(seq0);
      req1_x = i2f(seq1); req1_tag = TAGW'(seq1);
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; mon_en = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    req0_x = i2f(0); req0_tag = '0; req1_x = i2f(0); req1_tag = '0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    while (busy && n < 50) begin step(); n++; end
    @(negedge clk);
    check({name, "_idle"}, 32'(busy), 32'd0);
    check({name, "_q_empty"}, 32'(q0.size() + q1.size()), 32'd0);
    step();
  endtask

  function automatic logic rdy(input bit p);
    return p ? req1_ready : req0_ready;
  endfunction
  function automatic logic other_rdy(input bit p);
    return p ? req0_ready : req1_ready;
  endfunction

  typedef struct { bit port; logic [31:0] x; logic [TAGW-1:0] tag; logic [31:0] y; } vec_t;
  vec_t vecs [8];

  initial begin
    int acc;
    bit e0, e1;

    vecs[0] = '{1'b0, 32'h3FC00000, 4'd5, 32'd2};          // 1.5
    vecs[1] = '{1'b0, 32'hC0200000, 4'd6, 32'hFFFFFFFD};    // -2.5
    vecs[2] = '{1'b1, 32'h40490FDB, 4'd7, 32'd3};           // pi
    vecs[3] = '{1'b1, 32'h00000000, 4'd0, 32'd0};
    vecs[4] = '{1'b0, 32'h42F60000, 4'd9, 32'd123};
    vecs[5] = '{1'b1, 32'hC2C80000, 4'd3, 32'hFFFFFF9C};    // -100
    vecs[6] = '{1'b0, 32'h3F000000, 4'd1, 32'd1};           // 0.5
    vecs[7] = '{1'b1, 32'h3E800000, 4'd2, 32'd0};           // 0.25

    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req0_x = '0; req1_x = '0; req0_tag = '0; req1_tag = '0;
    #2 rst = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; req0_x = 32'h3F800000; req1_x = 32'h40000000;

    // Reset state, with both requesters offering
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_cvt_x", cvt_x, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);

    // Vector table: single op each, checking latency and result
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].port) begin req1_valid = 1'b1; req1_x = vecs[i].x; req1_tag = vecs[i].tag; end
      else              begin req0_valid = 1'b1; req0_x = vecs[i].x; req0_tag = vecs[i].tag; end
      @(negedge clk);
      check($sformatf("vec%0d_ready", i), 32'(rdy(vecs[i].port)), 32'd1);
      check($sformatf("vec%0d_other_ready", i), 32'(other_rdy(vecs[i].port)), 32'd0);
      check($sformatf("vec%0d_cvt_x", i), cvt_x, vecs[i].x);
      step();
      req0_valid = 1'b0; req1_valid = 1'b0;
      for (int k = 1; k <= NSTAGE; k++) begin
        @(negedge clk);
        check($sformatf("vec%0d_early_valid", i),
              32'(vecs[i].port ? rsp1_valid : rsp0_valid), 32'd0);
        step();
      end
      if (vecs[i].port) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(vecs[i].port ? rsp1_valid : rsp0_valid), 32'd1);
      check($sformatf("vec%0d_y", i), vecs[i].port ? rsp1_y : rsp0_y, vecs[i].y);
      check($sformatf("vec%0d_tag", i), 32'(vecs[i].port ? rsp1_tag : rsp0_tag), 32'(vecs[i].tag));
      step();
      rsp0_ready = 1'b0; rsp1_ready = 1'b0;
      @(negedge clk);
      check($sformatf("vec%0d_popped", i), 32'(rsp0_valid | rsp1_valid), 32'd0);
      check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
      step();
    end

    // Contention: both ports offering continuously, responses always drained
    do_reset();
    mon_en = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
`ifdef FCVT_ARB_RR_EN
      e0 = (k % 2 == 0); e1 = !e0;
`else
      e0 = 1'b1; e1 = 1'b0;
`endif
      @(negedge clk);
      check($sformatf("cont%0d_gnt0", k), 32'(req0_ready), 32'(e0));
      check($sformatf("cont%0d_gnt1", k), 32'(req1_ready), 32'(e1));
      step();
    end
    req0_valid = 1'b0;
    @(negedge clk);
    check("cont_p1_when_p0_idle", 32'(req1_ready), 32'd1);
    check("cont_p0_idle_no_gnt", 32'(req0_ready), 32'd0);
    step();
    req1_valid = 1'b0;
    drain("cont");

    // Backpressure on port 1: exactly FIFO_DEPTH accepts, port 0 unaffected
    do_reset();
    mon_en = 1'b1; rsp0_ready = 1'b1; req1_valid = 1'b1;
    acc = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (req1_ready) acc++;
      step();
    end
    check("bp_accepts", 32'(acc), 32'(FIFO_DEPTH));
    req0_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("bp%0d_p0_rate", k), 32'(req0_ready), 32'd1);
      check($sformatf("bp%0d_p1_blocked", k), 32'(req1_ready), 32'd0);
      step();
    end
    req0_valid = 1'b0; rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
    check("bp_rsp1_first_tag", 32'(rsp1_tag), 32'd0);
    check("bp_pop_no_same_cycle_credit", 32'(req1_ready), 32'd0);
    step();
    rsp1_ready = 1'b0;
    @(negedge clk);
    check("bp_credit_next_cycle", 32'(req1_ready), 32'd1);
    step();
    @(negedge clk);
    check("bp_single_credit", 32'(req1_ready), 32'd0);
    step();
    req1_valid = 1'b0;
    drain("bp");
    check("bp_pops1", 32'(pops1), 32'(FIFO_DEPTH + 1));

    // Full FIFO0 (3 held + 1 in flight): pop and retire on the same edge
    do_reset();
    mon_en = 1'b1; req0_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check($sformatf("ff%0d_ready", k), 32'(req0_ready), 32'(k < 4));
      step();
    end
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("ff_popcycle_ready", 32'(req0_ready), 32'd0);
    check("ff_head_tag", 32'(rsp0_tag), 32'd0);
    step();
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("ff_one_credit", 32'(req0_ready), 32'd1);
    step();
    @(negedge clk);
    check("ff_count_held", 32'(req0_ready), 32'd0);
    step();
    req0_valid = 1'b0;
    drain("ff");
    check("ff_pops0", 32'(pops0), 32'd5);

    // Reset with two ops in flight and one FIFO entry
    do_reset();
    mon_en = 1'b1; req0_valid = 1'b1;
    repeat (3) begin @(negedge clk); step(); end
    req0_valid = 1'b0;
    @(negedge clk);
    check("rmf_pre_valid", 32'(rsp0_valid), 32'd1);
    check("rmf_pre_busy", 32'(busy), 32'd1);
    step();
    rst = 1'b1; req0_valid = 1'b1;
    @(negedge clk);
    check("rmf_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rmf_ready0", 32'(req0_ready), 32'd0);
    check("rmf_busy", 32'(busy), 32'd0);
    check("rmf_cvt_x", cvt_x, 32'h0);
    step();
    rst = 1'b0; req0_valid = 1'b0;
    for (int k = 0; k < NSTAGE + 2; k++) begin
      @(negedge clk);
      check($sformatf("rmf%0d_no_rsp", k), 32'(rsp0_valid | rsp1_valid), 32'd0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
